// File: rtl/array_responder_pkg.sv
// Shared definitions for the Array channel responder and its initiators.
package array_responder_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned INT_W_DEF  = 8;

    // Request payload as seen on the Array channel at default widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic                  we;
        logic [INT_W_DEF-1:0]  di;
    } array_req_t;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage

// File: rtl/array_responder_ram_sp.sv
// Single-port RAM: synchronous write, combinational read port, no reset.
module ram_sp
    import array_responder_pkg::*;
#(
    parameter int unsigned addrN = ADDR_W_DEF,
    parameter int unsigned intN  = INT_W_DEF
) (
    input  logic             clk,
    input  logic             we,
    input  logic [addrN-1:0] addr,
    input  logic [intN-1:0]  di,
    output logic [intN-1:0]  dout
);

    localparam int unsigned DEPTH = depth_of(addrN);

    logic [intN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= di;
        end
    end

    // Read data is captured by the responder's output register.
    assign dout = mem[addr];

endmodule

// File: rtl/array_responder.sv
// Array channel responder: one request per two cycles over a single-port RAM,
// with an optional post-reset clear sweep. Read data is presented on dout.
module array_responder
    import array_responder_pkg::*;
#(
    parameter int unsigned addrN = ADDR_W_DEF,
    parameter int unsigned intN  = INT_W_DEF,
    parameter bit          CLEAR = 1'b1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [addrN-1:0] addr,
    input  logic             we,
    input  logic [intN-1:0]  di,
    input  logic             valid,
    output logic [intN-1:0]  dout,
    output logic             ready,
    output logic             init_done
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_BUSY
    } state_t;

    localparam state_t           ST_RESET = CLEAR ? ST_CLEAR : ST_IDLE;
    localparam logic [addrN-1:0] CNT_LAST = '1;

    state_t           state;
    state_t           state_next;
    logic [addrN-1:0] clr_cnt;
    logic             ram_we;
    logic [addrN-1:0] ram_addr;
    logic [intN-1:0]  ram_di;
    logic [intN-1:0]  ram_rdata;
    logic             rd_load;

    // Next state and RAM port muxing between the clear sweep and requests.
    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_addr   = addr;
        ram_di     = di;
        rd_load    = 1'b0;
        case (state)
            ST_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = clr_cnt;
                ram_di   = '0;
                if (clr_cnt == CNT_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (valid) begin
                    state_next = ST_BUSY;
                    ram_we     = we;
                    rd_load    = !we;
                end
            end
            ST_BUSY: begin
                // valid is deliberately ignored: the initiator retires here.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + addrN'(1);
        end
    end

    // Registered outputs; dout only moves on an accepted read.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dout      <= '0;
            ready     <= 1'b0;
            init_done <= 1'b0;
        end else begin
            if (rd_load) begin
                dout <= ram_rdata;
            end
            ready     <= (state_next == ST_BUSY);
            init_done <= (state_next != ST_CLEAR);
        end
    end

    ram_sp #(
        .addrN (addrN),
        .intN  (intN)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .di   (ram_di),
        .dout (ram_rdata)
    );

endmodule

// File: tb/tb_array_responder.sv
// Bench for array_responder: one instance without and one with the clear sweep,
// each checked against an array-based memory model.
module tb_array_responder;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: CLEAR=0 instance, index 1: CLEAR=1 instance.
    logic          nrst_v  [2];
    logic [AW-1:0] addr_v  [2];
    logic          we_v    [2];
    logic [DW-1:0] di_v    [2];
    logic          valid_v [2];
    logic [DW-1:0] dout_v  [2];
    logic          ready_v [2];
    logic          init_v  [2];

    array_responder #(.addrN(AW), .intN(DW), .CLEAR(1'b0)) u_dut0 (
        .clk(clk), .nrst(nrst_v[0]), .addr(addr_v[0]), .we(we_v[0]), .di(di_v[0]),
        .valid(valid_v[0]), .dout(dout_v[0]), .ready(ready_v[0]), .init_done(init_v[0])
    );

    array_responder #(.addrN(AW), .intN(DW), .CLEAR(1'b1)) u_dut1 (
        .clk(clk), .nrst(nrst_v[1]), .addr(addr_v[1]), .we(we_v[1]), .di(di_v[1]),
        .valid(valid_v[1]), .dout(dout_v[1]), .ready(ready_v[1]), .init_done(init_v[1])
    );

    logic [DW-1:0] model_mem [2][DEPTH];
    logic [DW-1:0] exp_do    [2];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int s);
        exp_do[s] = '0;
        if (s == 1) begin
            for (int i = 0; i < DEPTH; i++) model_mem[s][i] = '0;
        end
    endtask

    task automatic wait_init(input int s, input int exp_cycles, input string tag);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (init_v[s] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
            if (ready_v[s] !== 1'b0) bad++;
        end
        check($sformatf("%s_len%0d", tag, s), n, exp_cycles);
        check($sformatf("%s_rdy%0d", tag, s), bad, 0);
    endtask

    // Issue one request at a negedge and wait for its ready pulse.
    task automatic do_req(input int s, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int lat, input logic hold);
        int n;
        addr_v[s]  = a;
        we_v[s]    = w;
        di_v[s]    = d;
        valid_v[s] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready_v[s] !== 1'b1 && n < 20);
        check($sformatf("lat%0d_%s_a%0d", s, w ? "wr" : "rd", a), n, lat);
        if (w) model_mem[s][a] = d;
        else   exp_do[s] = model_mem[s][a];
        check($sformatf("do%0d_%s_a%0d", s, w ? "wr" : "rd", a), dout_v[s], exp_do[s]);
        if (!hold) begin
            valid_v[s] = 1'b0;
            addr_v[s]  = 'x;
            we_v[s]    = 'x;
            di_v[s]    = 'x;
            @(negedge clk);
            check($sformatf("pulse%0d", s), ready_v[s], 0);
        end
    endtask

    task automatic rst_busy(input int s);
        addr_v[s]  = 7;
        we_v[s]    = 1'b1;
        di_v[s]    = 8'h55;
        valid_v[s] = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("busy_rdy%0d", s), ready_v[s], 1);
        nrst_v[s]  = 1'b0;
        valid_v[s] = 1'b0;
        #1;
        check($sformatf("rst_rdy%0d", s), ready_v[s], 0);
        check($sformatf("rst_do%0d", s), dout_v[s], 0);
        check($sformatf("rst_init%0d", s), init_v[s], 0);
        model_mem[s][7] = 8'h55;
        @(negedge clk);
        nrst_v[s] = 1'b1;
        model_reset(s);
        wait_init(s, (s == 1) ? 256 : 1, "rbusy");
        do_req(s, 1'b0, 7, 0, 1, 1'b0);
        check($sformatf("rbusy_val%0d", s), dout_v[s], (s == 1) ? 0 : 32'h55);
    endtask

    initial begin
        logic prev_hold;
        logic hold;
        logic w;
        for (int s = 0; s < 2; s++) begin
            nrst_v[s]  = 1'b1;
            valid_v[s] = 1'b0;
            addr_v[s]  = '0;
            we_v[s]    = 1'b0;
            di_v[s]    = '0;
        end
        #2;
        nrst_v[0] = 1'b0;
        nrst_v[1] = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset_ready%0d", s), ready_v[s], 0);
            check($sformatf("reset_do%0d", s), dout_v[s], 0);
            check($sformatf("reset_init%0d", s), init_v[s], 0);
        end
        repeat (3) @(negedge clk);

        // Clear sweep with a read of addr 200 held pending throughout.
        addr_v[1]  = 200;
        we_v[1]    = 1'b0;
        valid_v[1] = 1'b1;
        nrst_v[0]  = 1'b1;
        nrst_v[1]  = 1'b1;
        model_reset(0);
        model_reset(1);
        wait_init(1, 256, "clear");
        check("init0", init_v[0], 1);
        do_req(1, 1'b0, 200, 0, 1, 1'b0);

        // Give the CLEAR=0 instance defined contents everywhere.
        for (int a = 0; a < DEPTH; a++)
            do_req(0, 1'b1, AW'(a), DW'($urandom), (a == 0) ? 1 : 2, a != DEPTH - 1);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) do_req(s, 1'b1, AW'(i), DW'(i * 7), 1, 1'b0);
            for (int i = 0; i < 8; i++) begin
                do_req(s, 1'b0, AW'(i), 0, 1, 1'b0);
                check($sformatf("wrrd%0d_%0d", s, i), dout_v[s], i * 7);
            end
        end

        // Back-to-back alternate write/read of addr 5.
        for (int k = 0; k < 8; k++)
            do_req(1, (k % 2) == 0, 5, (k == 0) ? 8'h3C : DW'($urandom),
                   (k == 0) ? 1 : 2, k != 7);
        check("b2b_idle", ready_v[1], 0);

        for (int s = 0; s < 2; s++) begin
            do_req(s, 1'b0, 3, 0, 1, 1'b0);
            check($sformatf("hold_rd%0d", s), dout_v[s], 21);
            do_req(s, 1'b1, 3, 99, 1, 1'b0);
            check($sformatf("hold_wr%0d", s), dout_v[s], 21);
            do_req(s, 1'b0, 3, 0, 1, 1'b0);
            check($sformatf("hold_new%0d", s), dout_v[s], 99);

            do_req(s, 1'b1, 255, 8'hAA, 1, 1'b0);
            do_req(s, 1'b1, 0, 8'h11, 1, 1'b0);
            do_req(s, 1'b0, 255, 0, 1, 1'b0);
            check($sformatf("bound_hi%0d", s), dout_v[s], 32'hAA);
            do_req(s, 1'b0, 0, 0, 1, 1'b0);
            check($sformatf("bound_lo%0d", s), dout_v[s], 32'h11);
        end

        // Randomized traffic per instance with random back-to-back and gaps.
        for (int s = 0; s < 2; s++) begin
            prev_hold = 1'b0;
            for (int k = 0; k < 150; k++) begin
                hold = (k != 149) && ($urandom_range(0, 1) == 1);
                w    = ($urandom_range(0, 1) == 1);
                do_req(s, w, AW'($urandom), DW'($urandom), prev_hold ? 2 : 1, hold);
                if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
                prev_hold = hold;
            end
        end

        // Reset during the clear sweep restarts it from the beginning.
        nrst_v[1] = 1'b0;
        @(negedge clk);
        nrst_v[1] = 1'b1;
        repeat (100) @(negedge clk);
        nrst_v[1] = 1'b0;
        @(negedge clk);
        nrst_v[1] = 1'b1;
        model_reset(1);
        wait_init(1, 256, "clear2");
        do_req(1, 1'b0, AW'($urandom), 0, 1, 1'b0);

        rst_busy(0);
        rst_busy(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
